// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM stage: access sizes, exception causes and FSM states.
package riscv_pkg;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  localparam int ECAUSE_INSTR_MISALIGNED = 0;
  localparam int ECAUSE_LOAD_MISALIGNED  = 4;
  localparam int ECAUSE_LOAD_FAULT       = 5;
  localparam int ECAUSE_STORE_MISALIGNED = 6;
  localparam int ECAUSE_STORE_FAULT      = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } mem_state_e;

endpackage

// File: rtl/memory_unit_lsu_align.sv
// Byte-lane steering: store strobes/lane replication and load extract with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             sign,
  input  logic [XLEN-1:0]  st_data,
  input  logic [XLEN-1:0]  ld_raw,
  output logic [BYTES-1:0] wstrb,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  ld_data
);

  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  mask;
  logic [BYTES-1:0] base;
  logic             sbit;

  always_comb begin
    shifted = ld_raw >> {off, 3'b000};
    base    = '0;
    mask    = '1;
    sbit    = 1'b0;
    case (size)
      SIZE_BYTE: begin
        base = BYTES'(8'h01);
        mask = XLEN'(64'h0000_0000_0000_00FF);
        sbit = shifted[7];
      end
      SIZE_HALF: begin
        base = BYTES'(8'h03);
        mask = XLEN'(64'h0000_0000_0000_FFFF);
        sbit = shifted[15];
      end
      SIZE_WORD: begin
        base = BYTES'(8'h0F);
        mask = XLEN'(64'h0000_0000_FFFF_FFFF);
        sbit = shifted[31];
      end
      default: begin
        base = BYTES'(8'hFF);
        mask = '1;
        sbit = shifted[XLEN-1];
      end
    endcase
    wstrb   = base << off;
    wdata   = st_data << {off, 3'b000};
    ld_data = (shifted & mask) | ((sign && sbit) ? ~mask : '0);
  end

endmodule

// File: rtl/memory_unit.sv
// MEM pipeline stage: branch resolve, load/store over a req/ack bus, exception merge, WB registers.
module memory_unit
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int C_EXT    = 0,
  parameter int ECAUSE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       next_pc_in,
  input  logic [XLEN-1:0]       alu_data_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic [XLEN-1:0]       csr_data_in,
  input  logic                  branch_taken_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic                  load_signed_in,
  input  logic [1:0]            load_store_size_in,
  input  logic [1:0]            write_select_in,
  input  logic [4:0]            rd_address_in,
  input  logic [11:0]           csr_address_in,
  input  logic                  csr_write_in,
  input  logic                  mret_in,
  input  logic                  wfi_in,
  input  logic                  valid_in,
  input  logic                  exception_in,
  input  logic [ECAUSE_W-1:0]   ecause_in,
  input  logic                  stall,
  input  logic                  invalidate,
  output logic                  mem_busy,
  output logic                  branch_taken,
  output logic [XLEN-1:0]       branch_address,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_wstrb,
  input  logic                  mem_ack,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_err,
  output logic [XLEN-1:0]       pc_out,
  output logic [XLEN-1:0]       next_pc_out,
  output logic [XLEN-1:0]       alu_data_out,
  output logic [XLEN-1:0]       csr_data_out,
  output logic [XLEN-1:0]       load_data_out,
  output logic [1:0]            write_select_out,
  output logic [4:0]            rd_address_out,
  output logic [11:0]           csr_address_out,
  output logic                  csr_write_out,
  output logic                  mret_out,
  output logic                  wfi_out,
  output logic                  valid_out,
  output logic                  exception_out,
  output logic [ECAUSE_W-1:0]   ecause_out,
  output mem_state_e            state_dbg
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     next_pc;
    logic [XLEN-1:0]     alu_data;
    logic [XLEN-1:0]     csr_data;
    logic [XLEN-1:0]     load_data;
    logic [1:0]          write_select;
    logic [4:0]          rd_address;
    logic [11:0]         csr_address;
    logic                csr_write;
    logic                mret;
    logic                wfi;
    logic                valid;
    logic                exception;
    logic [ECAUSE_W-1:0] ecause;
  } wb_t;

  mem_state_e       state;
  wb_t              wb, pend, ex_res, fin, hold_res;
  logic [OFF_W-1:0] req_off, al_off;
  logic [1:0]       req_size, al_size;
  logic             req_sign, kill;
  logic             go, is_mem, ls_mis, target_ok, br_mis, start;
  logic [BYTES-1:0] al_wstrb;
  logic [XLEN-1:0]  al_wdata, al_ld;

  assign go        = valid_in & ~exception_in & ~invalidate;
  assign is_mem    = load_in | store_in;
  assign target_ok = (C_EXT != 0) ? ~alu_data_in[0] : (alu_data_in[1:0] == 2'b00);
  assign br_mis    = branch_taken_in & ~target_ok;

  always_comb begin
    case (load_store_size_in)
      SIZE_BYTE: ls_mis = 1'b0;
      SIZE_HALF: ls_mis = alu_data_in[0];
      SIZE_WORD: ls_mis = |alu_data_in[1:0];
      default:   ls_mis = (XLEN == 32) || (|alu_data_in[2:0]);
    endcase
  end

  assign branch_taken   = go & branch_taken_in & target_ok;
  assign branch_address = alu_data_in;
  assign start     = (state == IDLE) & go & is_mem & ~ls_mis & ~br_mis & ~stall;
  assign mem_busy  = (state == REQ) | start;
  assign state_dbg = state;

  assign al_off  = (state == IDLE) ? alu_data_in[OFF_W-1:0] : req_off;
  assign al_size = (state == IDLE) ? load_store_size_in : req_size;

  lsu_align #(.XLEN(XLEN)) u_align (
    .off     (al_off),
    .size    (al_size),
    .sign    (req_sign),
    .st_data (rs2_data_in),
    .ld_raw  (mem_rdata),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata),
    .ld_data (al_ld)
  );

  // Result of an op that does not touch the bus; the exception chain is in priority order.
  always_comb begin
    ex_res              = '0;
    ex_res.pc           = pc_in;
    ex_res.next_pc      = next_pc_in;
    ex_res.alu_data     = alu_data_in;
    ex_res.csr_data     = csr_data_in;
    ex_res.write_select = write_select_in;
    ex_res.rd_address   = rd_address_in;
    ex_res.csr_address  = csr_address_in;
    ex_res.csr_write    = csr_write_in;
    ex_res.mret         = mret_in;
    ex_res.wfi          = wfi_in;
    ex_res.valid        = valid_in & ~invalidate;
    if (exception_in) begin
      ex_res.exception = 1'b1;
      ex_res.ecause    = ecause_in;
    end else if (br_mis) begin
      ex_res.exception = 1'b1;
      ex_res.ecause    = ECAUSE_W'(ECAUSE_INSTR_MISALIGNED);
    end else if (is_mem && ls_mis) begin
      ex_res.exception = 1'b1;
      ex_res.ecause    = store_in ? ECAUSE_W'(ECAUSE_STORE_MISALIGNED)
                                  : ECAUSE_W'(ECAUSE_LOAD_MISALIGNED);
    end
    ex_res.exception = ex_res.exception & ex_res.valid;
  end

  always_comb begin
    fin           = pend;
    fin.valid     = pend.valid & ~(kill | invalidate);
    fin.load_data = (mem_we | mem_err) ? '0 : al_ld;
    fin.exception = fin.valid & mem_err;
    fin.ecause    = mem_err ? (mem_we ? ECAUSE_W'(ECAUSE_STORE_FAULT)
                                      : ECAUSE_W'(ECAUSE_LOAD_FAULT)) : '0;
    hold_res           = pend;
    hold_res.valid     = pend.valid & ~(kill | invalidate);
    hold_res.exception = pend.exception & hold_res.valid;
  end

  // Bus handshake: mem_req rises with addr/we/wdata/wstrb already stable and stays high,
  // unchanged, until a cycle in which mem_ack is high; that cycle completes the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      req_off   <= '0;
      req_size  <= '0;
      req_sign  <= 1'b0;
      kill      <= 1'b0;
      pend      <= '0;
      wb        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= store_in;
            mem_addr  <= {alu_data_in[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata <= al_wdata;
            mem_wstrb <= store_in ? al_wstrb : '0;
            req_off   <= alu_data_in[OFF_W-1:0];
            req_size  <= load_store_size_in;
            req_sign  <= load_signed_in;
            kill      <= 1'b0;
            pend      <= ex_res;
            wb.valid  <= 1'b0;
            state     <= REQ;
          end else if (!stall) begin
            wb <= ex_res;
          end
        end
        REQ: begin
          kill <= kill | invalidate;
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            if (!stall) begin
              wb    <= fin;
              state <= IDLE;
            end else begin
              pend  <= fin;
              state <= HOLD;
            end
          end else if (!stall) begin
            wb.valid <= 1'b0;
          end
        end
        HOLD: begin
          kill <= kill | invalidate;
          if (!stall) begin
            wb    <= hold_res;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_out           = wb.pc;
  assign next_pc_out      = wb.next_pc;
  assign alu_data_out     = wb.alu_data;
  assign csr_data_out     = wb.csr_data;
  assign load_data_out    = wb.load_data;
  assign write_select_out = wb.write_select;
  assign rd_address_out   = wb.rd_address;
  assign csr_address_out  = wb.csr_address;
  assign csr_write_out    = wb.csr_write;
  assign mret_out         = wb.mret;
  assign wfi_out          = wb.wfi;
  assign valid_out        = wb.valid;
  assign exception_out    = wb.exception;
  assign ecause_out       = wb.ecause;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed ops, bus responder in the driver, WB scoreboard.
module tb_memory_unit;
  import riscv_pkg::*;

  localparam int EXP_W = 42;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
  logic        branch_taken_in, load_in, store_in, load_signed_in;
  logic [1:0]  load_store_size_in, write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        csr_write_in, mret_in, wfi_in, valid_in, exception_in;
  logic [3:0]  ecause_in;
  logic        stall, invalidate;
  logic        mem_busy, branch_taken, mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] branch_address, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_address_out;
  logic [11:0] csr_address_out;
  logic        csr_write_out, mret_out, wfi_out, valid_out, exception_out;
  logic [3:0]  ecause_out;
  mem_state_e  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];

  memory_unit #(.XLEN(32), .C_EXT(0), .ECAUSE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .next_pc_in(next_pc_in),
    .alu_data_in(alu_data_in), .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
    .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
    .load_signed_in(load_signed_in), .load_store_size_in(load_store_size_in),
    .write_select_in(write_select_in), .rd_address_in(rd_address_in),
    .csr_address_in(csr_address_in), .csr_write_in(csr_write_in), .mret_in(mret_in),
    .wfi_in(wfi_in), .valid_in(valid_in), .exception_in(exception_in),
    .ecause_in(ecause_in), .stall(stall), .invalidate(invalidate),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .branch_address(branch_address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .load_data_out(load_data_out),
    .write_select_out(write_select_out), .rd_address_out(rd_address_out),
    .csr_address_out(csr_address_out), .csr_write_out(csr_write_out),
    .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
    .exception_out(exception_out), .ecause_out(ecause_out), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(input logic [4:0] rd, input logic exc,
                                                input logic [3:0] ec, input logic [31:0] data);
    return {rd, exc, ec, data};
  endfunction

  // Driver tasks
  task automatic clear_op();
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; load_signed_in = 1'b0;
    branch_taken_in = 1'b0; exception_in = 1'b0; ecause_in = '0; invalidate = 1'b0;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic sgn, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic br,
                        input logic exc, input logic [3:0] ec, input logic [4:0] rd,
                        input logic inv);
    valid_in = 1'b1; load_in = ld; store_in = st; load_signed_in = sgn;
    load_store_size_in = sz; alu_data_in = addr; rs2_data_in = rs2;
    branch_taken_in = br; exception_in = exc; ecause_in = ec; rd_address_in = rd;
    invalidate = inv;
    pc_in = 32'h1000 + {27'd0, rd}; next_pc_in = pc_in + 32'd4;
  endtask

  task automatic run_simple(input logic e_branch);
    #1;
    check("busy_simple", {63'd0, mem_busy}, 64'd0);
    check("branch_taken", {63'd0, branch_taken}, {63'd0, e_branch});
    @(negedge clk);
    clear_op();
    #1 check("no_req", {63'd0, mem_req}, 64'd0);
  endtask

  task automatic run_mem(input int wt, input logic [31:0] rdata, input logic err,
                         input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_wstrb,
                         input logic [31:0] e_wdata, input logic inv, input int hold_cyc);
    int busy_n;
    busy_n = 0;
    #1 if (mem_busy) busy_n++;
    for (int k = 1; k <= wt; k++) begin
      @(negedge clk);
      clear_op();
      invalidate = inv && (k == 1);
      if (k == 1) begin
        check("mem_req", {63'd0, mem_req}, 64'd1);
        check("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
        check("mem_we", {63'd0, mem_we}, {63'd0, e_we});
        check("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, e_wstrb});
        if (e_we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});
      end
      if (k == 2 && inv) check("req_held_after_inv", {63'd0, mem_req}, 64'd1);
      if (k == wt) begin
        mem_ack = 1'b1; mem_rdata = rdata; mem_err = err;
        stall = (hold_cyc > 0);
      end
      #1 if (mem_busy) busy_n++;
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_err = 1'b0; invalidate = 1'b0;
    for (int h = 0; h < hold_cyc; h++) begin
      #1 check("hold_busy", {63'd0, mem_busy}, 64'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1 check("req_done", {63'd0, mem_req}, 64'd0);
    check("busy_cycles", 64'(busy_n), 64'(1 + wt));
  endtask

  // Scoreboard monitor: a result is new when valid_out is high after an unstalled edge
  initial begin
    logic st;
    logic [EXP_W-1:0] got, e;
    forever begin
      @(posedge clk);
      st = stall;
      #1;
      if (rst_n && !st && valid_out) begin
        got = {rd_address_out, exception_out, ecause_out, load_data_out};
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(got), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_result", 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    csr_data_in = 32'h0; write_select_in = 2'd0; csr_address_in = 12'h0;
    csr_write_in = 1'b0; mret_in = 1'b0; wfi_in = 1'b0; rd_address_in = '0;
    alu_data_in = '0; rs2_data_in = '0; load_store_size_in = '0; pc_in = '0; next_pc_in = '0;
    clear_op();
    repeat (3) @(negedge clk);
    check("rst_valid_out", {63'd0, valid_out}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_wstrb", {60'd0, mem_wstrb}, 64'd0);
    check("rst_load_data", {32'd0, load_data_out}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, {62'd0, IDLE});
    rst_n = 1'b1;

    // lw 0x104, ack on third request cycle
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd1, 1'b0, 4'd0, 32'hDEADBEEF));
    set_op(1, 0, 0, SIZE_WORD, 32'h104, 32'h0, 0, 0, 0, 5'd1, 0);
    run_mem(3, 32'hDEADBEEF, 0, 32'h104, 0, 4'h0, 32'h0, 0, 0);

    // lb / lbu at 0x103
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd2, 1'b0, 4'd0, 32'hFFFFFF80));
    set_op(1, 0, 1, SIZE_BYTE, 32'h103, 32'h0, 0, 0, 0, 5'd2, 0);
    run_mem(1, 32'h80FFFFFF, 0, 32'h100, 0, 4'h0, 32'h0, 0, 0);
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd3, 1'b0, 4'd0, 32'h00000080));
    set_op(1, 0, 0, SIZE_BYTE, 32'h103, 32'h0, 0, 0, 0, 5'd3, 0);
    run_mem(2, 32'h80FFFFFF, 0, 32'h100, 0, 4'h0, 32'h0, 0, 0);

    // lh signed at 0x102 (upper half)
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd4, 1'b0, 4'd0, 32'hFFFFABCD));
    set_op(1, 0, 1, SIZE_HALF, 32'h102, 32'h0, 0, 0, 0, 5'd4, 0);
    run_mem(1, 32'hABCD1234, 0, 32'h100, 0, 4'h0, 32'h0, 0, 0);

    // sh 0x202 and sb 0x201
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd0, 1'b0, 4'd0, 32'h0));
    set_op(0, 1, 0, SIZE_HALF, 32'h202, 32'h1234, 0, 0, 0, 5'd0, 0);
    run_mem(1, 32'h0, 0, 32'h200, 1, 4'b1100, 32'h12340000, 0, 0);
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd0, 1'b0, 4'd0, 32'h0));
    set_op(0, 1, 0, SIZE_BYTE, 32'h201, 32'h000000A5, 0, 0, 0, 5'd0, 0);
    run_mem(2, 32'h0, 0, 32'h200, 1, 4'b0010, 32'h0000A500, 0, 0);

    // Misaligned load/store/double, misaligned and aligned jumps, upstream exception
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd5, 1'b1, 4'd4, 32'h0));
    set_op(1, 0, 0, SIZE_WORD, 32'h101, 32'h0, 0, 0, 0, 5'd5, 0);
    run_simple(0);
    exp_q.push_back(pack_exp(5'd6, 1'b1, 4'd6, 32'h0));
    set_op(0, 1, 0, SIZE_WORD, 32'h102, 32'h0, 0, 0, 0, 5'd6, 0);
    run_simple(0);
    exp_q.push_back(pack_exp(5'd7, 1'b1, 4'd0, 32'h0));
    set_op(0, 0, 0, SIZE_WORD, 32'h102, 32'h0, 1, 0, 0, 5'd7, 0);
    run_simple(0);
    exp_q.push_back(pack_exp(5'd8, 1'b0, 4'd0, 32'h0));
    set_op(0, 0, 0, SIZE_WORD, 32'h104, 32'h0, 1, 0, 0, 5'd8, 0);
    run_simple(1);
    exp_q.push_back(pack_exp(5'd10, 1'b1, 4'd2, 32'h0));
    set_op(1, 0, 0, SIZE_WORD, 32'h101, 32'h0, 0, 1, 4'd2, 5'd10, 0);
    run_simple(0);
    exp_q.push_back(pack_exp(5'd11, 1'b1, 4'd4, 32'h0));
    set_op(1, 0, 0, SIZE_DOUBLE, 32'h100, 32'h0, 0, 0, 0, 5'd11, 0);
    run_simple(0);
    exp_q.push_back(pack_exp(5'd12, 1'b0, 4'd0, 32'h0));
    set_op(0, 0, 0, SIZE_WORD, 32'h55, 32'h0, 0, 0, 0, 5'd12, 0);
    run_simple(0);

    // Bus access faults
    exp_q.push_back(pack_exp(5'd13, 1'b1, 4'd5, 32'h0));
    set_op(1, 0, 0, SIZE_WORD, 32'h300, 32'h0, 0, 0, 0, 5'd13, 0);
    run_mem(2, 32'h12345678, 1, 32'h300, 0, 4'h0, 32'h0, 0, 0);
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd14, 1'b1, 4'd7, 32'h0));
    set_op(0, 1, 0, SIZE_WORD, 32'h304, 32'hCAFEF00D, 0, 0, 0, 5'd14, 0);
    run_mem(1, 32'h0, 1, 32'h304, 1, 4'hF, 32'hCAFEF00D, 0, 0);

    // Invalidate in REQ: transfer completes, result dropped
    @(negedge clk);
    set_op(1, 0, 0, SIZE_WORD, 32'h108, 32'h0, 0, 0, 0, 5'd15, 0);
    run_mem(3, 32'h11112222, 0, 32'h108, 0, 4'h0, 32'h0, 1, 0);
    check("valid_after_inv_req", {63'd0, valid_out}, 64'd0);

    // Stall during ack: HOLD for two cycles, then emit
    @(negedge clk);
    exp_q.push_back(pack_exp(5'd9, 1'b0, 4'd0, 32'h13579BDF));
    set_op(1, 0, 0, SIZE_WORD, 32'h10C, 32'h0, 0, 0, 0, 5'd9, 0);
    run_mem(2, 32'h13579BDF, 0, 32'h10C, 0, 4'h0, 32'h0, 0, 2);

    // Invalidate in IDLE: nothing issued, bubble written
    @(negedge clk);
    set_op(1, 0, 0, SIZE_WORD, 32'h120, 32'h0, 0, 0, 0, 5'd16, 1);
    run_simple(0);
    check("valid_after_inv_idle", {63'd0, valid_out}, 64'd0);

    // Reset in REQ drops mem_req at once
    @(negedge clk);
    set_op(1, 0, 0, SIZE_WORD, 32'h110, 32'h0, 0, 0, 0, 5'd17, 0);
    @(negedge clk);
    clear_op();
    check("req_before_reset", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    #1 check("req_after_reset", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
